polyplay_rom_loader: RTL and testbench
======================================

// Module: polyplay_rom_loader
// PURPOSE
//  Staging block between hps_io ioctl download port and PolyPlay core dn_* port. Decodes index
//  (0 = ROM image, 1 = title number), buffers ROM bytes in a small FIFO, and issues them to the
//  core's write port under a ready handshake. Holds core in reset while loading.
//  Also keeps a byte count and additive checksum, and reports out-of-range writes.
// PARAMETERS
//  ADDR_W      16   core download address width (dn_addr)
//  ROM_MAX     16'hFFFF  highest accepted ROM byte address
//  FIFO_DEPTH  4    byte FIFO entries (power of 2, >=2)
//  HOLD_CYC    16   core_reset hold cycles after last ROM byte written
// PORTS
//  clk_sys        in   1   system clock (all logic)
//  reset          in   1   synchronous, active-high
//  ioctl_download in   1   high for the duration of a download
//  ioctl_index    in   8   download index; 0 = ROM, 1 = title no, others ignored
//  ioctl_wr       in   1   one-cycle byte strobe
//  ioctl_addr     in   25  byte address within download
//  ioctl_dout     in   8   byte data
//  ioctl_wait     out  1   back-pressure to hps_io; high = FIFO cannot take another byte
//  dn_addr        out  ADDR_W  core write address
//  dn_data        out  8   core write data
//  dn_wr          out  1   core write strobe; held until dn_ready seen
//  dn_ready       in   1   core accepts write in cycle where dn_wr & dn_ready
//  tno            out  8   latched title number
//  core_reset     out  1   high during ROM load and HOLD_CYC after
//  rom_len        out  ADDR_W+1  bytes accepted in last ROM download
//  rom_sum        out  16  sum of accepted ROM bytes, mod 2^16
//  rom_valid      out  1   last ROM download completed with no range error
//  err_range      out  1   sticky: ROM byte with ioctl_addr > ROM_MAX was dropped
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, dn_wr=0, ioctl_wait=0, tno=0, core_reset=1, rom_len=0,
//   rom_sum=0, rom_valid=0, err_range=0. HOLD counter loaded with HOLD_CYC.
//  States: IDLE -> LOAD on ioctl_download & index==0 (clears len/sum/valid/err_range).
//   LOAD -> DRAIN on ioctl_download falling. DRAIN -> HOLD when FIFO empty and no dn_wr pending.
//   HOLD counts HOLD_CYC cycles -> RUN. RUN -> LOAD on new index-0 download.
//   After reset, IDLE holds core_reset=1 for HOLD_CYC then goes RUN (core boots without a download).
//  core_reset = 1 in IDLE(counting), LOAD, DRAIN, HOLD; 0 only in RUN.
//  Index 1: any ioctl_wr with index==1 latches tno<=ioctl_dout next cycle, in any state; last byte wins.
//   Does not touch FIFO, len, sum or core_reset.
//  Index 0 bytes in LOAD: addr<=ROM_MAX -> push {addr[ADDR_W-1:0],data}; rom_len+=1,
//   rom_sum+=data (zero-extended, wraps). addr>ROM_MAX -> dropped, err_range<=1.
//  FIFO: push on accepted byte, pop on dn_wr&dn_ready; simultaneous push/pop on full is legal
//   (count unchanged). ioctl_wait = (count >= FIFO_DEPTH-1) registered, giving one slot of slack for
//   the in-flight strobe. A write arriving when truly full is dropped and sets err_range (protocol fault).
//  Core port: dn_wr/dn_addr/dn_data registered from FIFO head; dn_wr rises 1 cycle after head valid,
//   stays high with stable addr/data until dn_ready; next entry may present the following cycle
//   (max one write per 2 cycles not required; back-to-back allowed when dn_ready held high).
//  rom_valid <= !err_range on DRAIN->HOLD. Other indices are ignored entirely.
//  reset mid-load: FIFO flushed, dn_wr drops same edge, FSM to IDLE, counters cleared as above.
// STRUCTURE
//  Package polyplay_pkg: typedef enum {ST_IDLE,ST_LOAD,ST_DRAIN,ST_HOLD,ST_RUN} ldr_state_t;
//   localparams IDX_ROM=8'd0, IDX_TNO=8'd1.
//  Sub-module sync_fifo (WIDTH=ADDR_W+8, DEPTH=FIFO_DEPTH; push/pop/full/empty/count).
//  Top: FSM, hold counter, len/sum accumulators, tno latch, dn_* output register.
// TESTING
//  1. reset, no download -> core_reset=1 for 16 cycles then 0; dn_wr never asserted; tno=0.
//  2. index0 bytes 0x01,0x02,0x03 @ addr 0..2, dn_ready=1 -> three dn_wr with addr 0,1,2;
//     rom_len=3, rom_sum=0x0006, rom_valid=1, core_reset falls 16 cycles after drain.
//  3. dn_ready=0 while streaming 8 bytes -> ioctl_wait high after 3 buffered; release -> all 8
//     reach core in order, none lost, err_range=0.
//  4. index0 write at addr 0x10000 -> no dn_wr for it, err_range=1, rom_valid=0 at end.
//  5. index1 byte 0x05 then 0x07 during RUN -> tno=0x07; core_reset stays 0.
//  6. reset asserted with 2 bytes queued -> dn_wr=0 next cycle, FIFO empty, rom_len=0, IDLE.

Source files
------------

// File: rtl/polyplay_pkg.sv
// Shared types and constants for the PolyPlay ROM loader.
package polyplay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_RUN
  } ldr_state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_TNO = 8'd1;

endpackage

// File: rtl/polyplay_rom_loader_sync_fifo.sv
// Small synchronous FIFO. Exposes the head entry and the entry behind it so
// the consumer can present the next word in the same cycle the head retires.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [WIDTH-1:0]       next_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d, rd_nx;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pop only real entries; a push on full is legal only alongside a pop.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

  assign rd_nx   = rd_q + AW'(1);
  assign head_o  = mem_q[rd_q];
  assign next_o  = mem_q[rd_nx];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // Pointer and occupancy next-state; depth is a power of two so pointers wrap.
  always_comb begin
    rd_d  = rd_q + AW'(do_pop);
    wr_d  = wr_q + AW'(do_push);
    cnt_d = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  // Control state: pointers and count are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wr_data_i;
  end

endmodule

// File: rtl/polyplay_rom_loader.sv
// Stages hps_io ioctl downloads into the PolyPlay core download port:
// decodes the index, buffers ROM bytes, handshakes them into the core,
// holds the core in reset while loading and reports length/checksum/errors.
module polyplay_rom_loader
  import polyplay_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter int unsigned ROM_MAX    = 32'h0000_FFFF,
  parameter int          FIFO_DEPTH = 4,
  parameter int          HOLD_CYC   = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  input  logic              dn_ready,
  output logic [7:0]        tno,
  output logic              core_reset,
  output logic [ADDR_W:0]   rom_len,
  output logic [15:0]       rom_sum,
  output logic              rom_valid,
  output logic              err_range
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(HOLD_CYC + 2);
  localparam int FW = ADDR_W + 8;
  localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYC);

  ldr_state_t      state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [15:0]     sum_q, sum_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [7:0]      tno_q, tno_d;
  logic            wait_q, wait_d;
  logic            dn_wr_q, dn_wr_d;
  logic [ADDR_W-1:0] dn_addr_q;
  logic [7:0]      dn_data_q;
  logic            dn_load;
  logic [FW-1:0]   load_word;

  logic            f_push, f_pop, f_full, f_empty;
  logic [FW-1:0]   f_head, f_next;
  logic [CW-1:0]   f_count, cnt_nxt;

  logic            rom_start, rom_wr, addr_oor;

  assign rom_start = ioctl_download && (ioctl_index == IDX_ROM);
  assign rom_wr    = ioctl_wr && (ioctl_index == IDX_ROM);
  assign addr_oor  = {7'd0, ioctl_addr} > ROM_MAX;

  // The head entry stays in the FIFO until the core takes it.
  assign f_pop = dn_wr_q && dn_ready;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_sys),
    .rst       (reset),
    .push_i    (f_push),
    .pop_i     (f_pop),
    .wr_data_i ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
    .head_o    (f_head),
    .next_o    (f_next),
    .full_o    (f_full),
    .empty_o   (f_empty),
    .count_o   (f_count)
  );

  // FSM next-state plus length/checksum/error bookkeeping for ROM bytes.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    len_d   = len_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    err_d   = err_q;
    f_push  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (rom_start) begin
          state_d = ST_LOAD;
          len_d   = '0;
          sum_d   = '0;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
          if (hold_q <= HW'(1)) state_d = ST_RUN;
          else                  hold_d  = hold_q - HW'(1);
        end
      end
      ST_LOAD: begin
        if (rom_wr) begin
          if (addr_oor || (f_full && !f_pop)) begin
            err_d = 1'b1;
          end else begin
            f_push = 1'b1;
            len_d  = len_q + (ADDR_W + 1)'(1);
            sum_d  = sum_q + {8'd0, ioctl_dout};
          end
        end
        if (!ioctl_download) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (f_empty && !dn_wr_q) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LD;
          valid_d = !err_q;
        end
      end
      ST_HOLD: begin
        if (hold_q <= HW'(1)) state_d = ST_RUN;
        else                  hold_d  = hold_q - HW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Title number latch, back-pressure level and core-port presentation.
  always_comb begin
    tno_d     = (ioctl_wr && (ioctl_index == IDX_TNO)) ? ioctl_dout : tno_q;
    cnt_nxt   = f_count + CW'(f_push) - CW'(f_pop);
    wait_d    = (cnt_nxt >= WAIT_LVL);
    dn_wr_d   = dn_wr_q;
    dn_load   = 1'b0;
    load_word = f_head;
    if (!dn_wr_q) begin
      if (!f_empty) begin
        dn_load = 1'b1;
        dn_wr_d = 1'b1;
      end
    end else if (dn_ready) begin
      if (f_count >= CW'(2)) begin
        dn_load   = 1'b1;
        load_word = f_next;
        dn_wr_d   = 1'b1;
      end else begin
        dn_wr_d = 1'b0;
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= HOLD_LD;
      len_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tno_q   <= '0;
      wait_q  <= 1'b0;
      dn_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tno_q   <= tno_d;
      wait_q  <= wait_d;
      dn_wr_q <= dn_wr_d;
    end
  end

  // Core address/data register; only meaningful while dn_wr is high.
  always_ff @(posedge clk_sys) begin
    if (dn_load) {dn_addr_q, dn_data_q} <= load_word;
  end

  assign ioctl_wait = wait_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign tno        = tno_q;
  assign core_reset = (state_q != ST_RUN);
  assign rom_len    = len_q;
  assign rom_sum    = sum_q;
  assign rom_valid  = valid_q;
  assign err_range  = err_q;

endmodule

// File: tb/tb_polyplay_rom_loader.sv
// Bench for polyplay_rom_loader: boot, short load, back-pressure, a vector
// table of single-byte downloads, title latch, randomized loads, mid-load reset.
module tb_polyplay_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_ready;
  logic [7:0]  tno;
  logic        core_reset;
  logic [16:0] rom_len;
  logic [15:0] rom_sum;
  logic        rom_valid;
  logic        err_range;

  polyplay_rom_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_ready       (dn_ready),
    .tno            (tno),
    .core_reset     (core_reset),
    .rom_len        (rom_len),
    .rom_sum        (rom_sum),
    .rom_valid      (rom_valid),
    .err_range      (err_range)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_fail = 0;
  int dn_wr_cycles = 0;
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  logic rnd_ready = 1'b0;

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  data;
    int          n_wr;
    logic [16:0] len;
    logic [15:0] sum;
    logic        valid;
    logic        err;
    logic [7:0]  tno;
  } vec_t;
  vec_t vt[7];

  // Record every core write accepted (dn_wr & dn_ready) at the falling edge.
  always @(negedge clk_sys) begin
    if (dn_wr) dn_wr_cycles++;
    if (dn_wr && dn_ready) got_q.push_back({dn_addr, dn_data});
  end

  // Random core back-pressure when enabled.
  always @(posedge clk_sys) begin
    if (rnd_ready) begin
      #1 dn_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  // Behaves like hps_io: only strobes a byte while ioctl_wait is low.
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int k;
    k = 0;
    while (ioctl_wait && k < 300) begin
      tick();
      k++;
    end
    if (ioctl_wait) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_timeout: ioctl_wait stuck at 1, required 0");
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_stream();
    int k;
    k = 0;
    while (got_q.size() < exp_q.size() && k < 300) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_run(input string name);
    int k;
    k = 0;
    while (core_reset && k < 400) begin
      tick();
      k++;
    end
    chk(name, 32'(core_reset), 32'd0);
  endtask

  task automatic chk_stream(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  int cnt;
  int m_len;
  int m_sum;
  logic m_err;
  int nb;
  logic [24:0] ra;
  logic [7:0]  rd;

  initial begin
    vt[0] = '{8'd0, 25'h0000000, 8'hA5, 1, 17'd1, 16'h00A5, 1'b1, 1'b0, 8'h00};
    vt[1] = '{8'd0, 25'h000FFFF, 8'h3C, 1, 17'd1, 16'h003C, 1'b1, 1'b0, 8'h00};
    vt[2] = '{8'd0, 25'h0010000, 8'h77, 0, 17'd0, 16'h0000, 1'b0, 1'b1, 8'h00};
    vt[3] = '{8'd0, 25'h1FFFFFF, 8'h01, 0, 17'd0, 16'h0000, 1'b0, 1'b1, 8'h00};
    vt[4] = '{8'd1, 25'h0000000, 8'h42, 0, 17'd0, 16'h0000, 1'b0, 1'b1, 8'h42};
    vt[5] = '{8'd2, 25'h0000005, 8'h99, 0, 17'd0, 16'h0000, 1'b0, 1'b1, 8'h42};
    vt[6] = '{8'd0, 25'h0001234, 8'hFF, 1, 17'd1, 16'h00FF, 1'b1, 1'b0, 8'h42};

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    dn_ready = 1'b1;

    // Reset state, then boot without a download: 16 cycles of core_reset.
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_dn_wr", 32'(dn_wr), 32'd0);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_tno", 32'(tno), 32'd0);
    chk("rst_len", 32'(rom_len), 32'd0);
    chk("rst_sum", 32'(rom_sum), 32'd0);
    chk("rst_valid", 32'(rom_valid), 32'd0);
    chk("rst_err", 32'(err_range), 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_sys);
      if (!core_reset) break;
      cnt++;
    end
    chk("boot_hold_cycles", 32'(cnt), 32'd16);
    chk("boot_no_dn_wr", 32'(dn_wr_cycles), 32'd0);
    chk("boot_tno", 32'(tno), 32'd0);

    // Three bytes, core always ready.
    tick();
    got_q.delete();
    exp_q = '{24'h000001, 24'h000102, 24'h000203};
    start_dl(8'd0);
    for (int i = 0; i < 3; i++) send_byte(25'(i), 8'(i + 1));
    end_dl();
    wait_stream();
    // One cycle to see the drained FIFO, then the 16-cycle hold.
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_sys);
      if (!core_reset) break;
      cnt++;
    end
    chk("t2_reset_after_last_write", 32'(cnt), 32'd17);
    chk_stream("t2");
    chk("t2_len", 32'(rom_len), 32'd3);
    chk("t2_sum", 32'(rom_sum), 32'h0006);
    chk("t2_valid", 32'(rom_valid), 32'd1);
    chk("t2_err", 32'(err_range), 32'd0);

    // Back-pressure: core stalled while 8 bytes stream in.
    tick();
    got_q.delete();
    exp_q.delete();
    m_sum = 0;
    dn_ready = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 3; i++) begin
      send_byte(25'(32'h100 + i), 8'(i * 37 + 11));
      exp_q.push_back({16'(32'h100 + i), 8'(i * 37 + 11)});
      m_sum += (i * 37 + 11) % 256;
    end
    chk("t3_wait_at_3", 32'(ioctl_wait), 32'd1);
    repeat (5) tick();
    chk("t3_wait_held", 32'(ioctl_wait), 32'd1);
    chk("t3_dn_wr_held", 32'(dn_wr), 32'd1);
    chk("t3_dn_addr_stable", 32'(dn_addr), 32'h100);
    chk("t3_dn_data_stable", 32'(dn_data), 32'd11);
    dn_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      send_byte(25'(32'h100 + i), 8'(i * 37 + 11));
      exp_q.push_back({16'(32'h100 + i), 8'(i * 37 + 11)});
      m_sum += (i * 37 + 11) % 256;
    end
    end_dl();
    wait_stream();
    wait_run("t3_run");
    chk_stream("t3");
    chk("t3_len", 32'(rom_len), 32'd8);
    chk("t3_sum", 32'(rom_sum), 32'(16'(m_sum)));
    chk("t3_err", 32'(err_range), 32'd0);
    chk("t3_valid", 32'(rom_valid), 32'd1);

    // Vector table: one byte per download under various indices/addresses.
    for (int v = 0; v < 7; v++) begin
      got_q.delete();
      start_dl(vt[v].idx);
      send_byte(vt[v].addr, vt[v].data);
      end_dl();
      if (vt[v].idx == 8'd0) wait_run("vec_run");
      else repeat (3) tick();
      repeat (2) tick();
      chk("vec_nwr", 32'(got_q.size()), 32'(vt[v].n_wr));
      if (vt[v].n_wr > 0 && got_q.size() > 0)
        chk("vec_word", 32'(got_q[0]), 32'({vt[v].addr[15:0], vt[v].data}));
      chk("vec_len", 32'(rom_len), 32'(vt[v].len));
      chk("vec_sum", 32'(rom_sum), 32'(vt[v].sum));
      chk("vec_valid", 32'(rom_valid), 32'(vt[v].valid));
      chk("vec_err", 32'(err_range), 32'(vt[v].err));
      chk("vec_tno", 32'(tno), 32'(vt[v].tno));
      chk("vec_core_reset", 32'(core_reset), 32'd0);
    end

    // Title number during RUN: last byte wins, core keeps running.
    ioctl_index = 8'd1;
    ioctl_dout = 8'h05;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("t5_tno_first", 32'(tno), 32'h05);
    ioctl_dout = 8'h07;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    chk("t5_tno_last", 32'(tno), 32'h07);
    chk("t5_core_reset", 32'(core_reset), 32'd0);

    // Randomized loads against a plain list/sum model.
    for (int r = 0; r < 6; r++) begin
      got_q.delete();
      exp_q.delete();
      m_len = 0;
      m_sum = 0;
      m_err = 1'b0;
      rnd_ready = 1'b1;
      start_dl(8'd0);
      nb = int'($urandom_range(1, 12));
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 7) == 0) ra = 25'(32'h10000 + $urandom_range(0, 4095));
        else                           ra = 25'($urandom_range(0, 65535));
        rd = 8'($urandom_range(0, 255));
        send_byte(ra, rd);
        if (ra <= 25'h00FFFF) begin
          exp_q.push_back({ra[15:0], rd});
          m_len++;
          m_sum += int'(rd);
        end else begin
          m_err = 1'b1;
        end
      end
      end_dl();
      rnd_ready = 1'b0;
      @(posedge clk_sys);
      #2;
      dn_ready = 1'b1;
      wait_run("rnd_run");
      chk_stream("rnd");
      chk("rnd_len", 32'(rom_len), 32'(m_len));
      chk("rnd_sum", 32'(rom_sum), 32'(16'(m_sum)));
      chk("rnd_err", 32'(err_range), 32'(m_err));
      chk("rnd_valid", 32'(rom_valid), 32'(!m_err));
      chk("rnd_tno", 32'(tno), 32'h07);
    end

    // Reset with two bytes queued behind a stalled core.
    tick();
    got_q.delete();
    dn_ready = 1'b0;
    start_dl(8'd0);
    send_byte(25'h20, 8'hAA);
    send_byte(25'h21, 8'hBB);
    chk("t6_len_before", 32'(rom_len), 32'd2);
    chk("t6_dn_wr_before", 32'(dn_wr), 32'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6_dn_wr", 32'(dn_wr), 32'd0);
    chk("t6_len", 32'(rom_len), 32'd0);
    chk("t6_sum", 32'(rom_sum), 32'd0);
    chk("t6_wait", 32'(ioctl_wait), 32'd0);
    chk("t6_core_reset", 32'(core_reset), 32'd1);
    chk("t6_tno", 32'(tno), 32'd0);
    dn_ready = 1'b1;
    repeat (4) tick();
    chk("t6_fifo_flushed", 32'(got_q.size()), 32'd0);
    wait_run("t6_boot");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
